// File: rtl/pcie_reg_tlp_engine.sv
// Endpoint register file behind one memory BAR: executes 3DW MWr32/MRd32 (length 1) and returns a CplD per read.
// Optional build macro PCIE_REGS_WRCOUNT_EN turns register 0 into a read-only count of accepted MWr32s.
module pcie_reg_tlp_engine #(
    parameter int          NUM_REGS  = 32,
    parameter logic [31:0] RESET_VAL = 32'h0
) (
    input  logic        clk_in,
    input  logic        rstn,
    input  logic [12:0] cfg_busdev,
    input  logic [63:0] rx_data,
    input  logic        rx_sop,
    input  logic        rx_eop,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [63:0] tx_data,
    output logic        tx_sop,
    output logic        tx_eop,
    output logic        tx_valid,
    input  logic        tx_ready
);
    localparam int IDX_W = $clog2(NUM_REGS);

    localparam logic [2:0] RX_HDR0 = 3'd0;
    localparam logic [2:0] RX_HDR1 = 3'd1;
    localparam logic [2:0] RX_DATA = 3'd2;
    localparam logic [2:0] RX_DROP = 3'd3;
    localparam logic [2:0] RX_CPL  = 3'd4;

    localparam logic [1:0] TX_IDLE = 2'd0;
    localparam logic [1:0] TX_B0   = 2'd1;
    localparam logic [1:0] TX_B1   = 2'd2;
    localparam logic [1:0] TX_B2   = 2'd3;

    localparam logic [7:0] FT_MWR32 = 8'h40;
    localparam logic [7:0] FT_MRD32 = 8'h00;

    logic [2:0]  rx_state_q, rx_state_d;
    logic        rx_ready_q, rx_ready_d;
    logic [1:0]  tx_state_q, tx_state_d;
    logic [63:0] tx_data_q, tx_data_d;
    logic        tx_sop_q, tx_sop_d;
    logic        tx_eop_q, tx_eop_d;
    logic        tx_valid_q, tx_valid_d;
    logic [31:0] regs_q [NUM_REGS];
    logic [31:0] regs_d [NUM_REGS];

    logic [7:0]  ft_q, ft_d;
    logic [9:0]  len_q, len_d;
    logic [15:0] req_id_q, req_id_d;
    logic [7:0]  tag_q, tag_d;
    logic [3:0]  fbe_q, fbe_d;
    logic [7:0]  addr_q, addr_d;
    logic [31:0] rdata_q, rdata_d;

    logic             rx_fire, cpl_done, wr_en, rd_start;
    logic [IDX_W-1:0] wr_idx, rd_idx;
    logic [31:0]      wr_data;
    logic             unused_bits;

    assign rx_fire     = rx_valid && rx_ready_q;
    assign cpl_done    = tx_valid_q && tx_ready && tx_eop_q;
    assign rd_idx      = rx_data[3 +: IDX_W];
    assign unused_bits = ^{rx_data[39:36], rx_data[23:10]};

    assign rx_ready = rx_ready_q;
    assign tx_data  = tx_data_q;
    assign tx_sop   = tx_sop_q;
    assign tx_eop   = tx_eop_q;
    assign tx_valid = tx_valid_q;

    // RX header decode; unsupported TLPs fall into RX_DROP until eop
    always_comb begin
        rx_state_d = rx_state_q;
        ft_d       = ft_q;
        len_d      = len_q;
        req_id_d   = req_id_q;
        tag_d      = tag_q;
        fbe_d      = fbe_q;
        addr_d     = addr_q;
        wr_en      = 1'b0;
        wr_data    = rx_data[63:32];
        wr_idx     = rx_data[3 +: IDX_W];
        rd_start   = 1'b0;
        case (rx_state_q)
            RX_HDR0: if (rx_fire && rx_sop) begin
                ft_d       = rx_data[31:24];
                len_d      = rx_data[9:0];
                req_id_d   = rx_data[63:48];
                tag_d      = rx_data[47:40];
                fbe_d      = rx_data[35:32];
                rx_state_d = rx_eop ? RX_HDR0 : RX_HDR1;
            end
            RX_HDR1: if (rx_fire) begin
                addr_d = rx_data[7:0];
                if (len_q == 10'd1 && ft_q == FT_MWR32) begin
                    if (rx_data[2]) begin
                        wr_en      = 1'b1;
                        rx_state_d = rx_eop ? RX_HDR0 : RX_DROP;
                    end else begin
                        rx_state_d = rx_eop ? RX_HDR0 : RX_DATA;
                    end
                end else if (len_q == 10'd1 && ft_q == FT_MRD32 && rx_eop) begin
                    rd_start   = 1'b1;
                    rx_state_d = RX_CPL;
                end else begin
                    rx_state_d = rx_eop ? RX_HDR0 : RX_DROP;
                end
            end
            RX_DATA: if (rx_fire) begin
                wr_en      = 1'b1;
                wr_data    = rx_data[31:0];
                wr_idx     = addr_q[3 +: IDX_W];
                rx_state_d = rx_eop ? RX_HDR0 : RX_DROP;
            end
            RX_DROP: if (rx_fire && rx_eop) rx_state_d = RX_HDR0;
            RX_CPL:  if (cpl_done) rx_state_d = RX_HDR0;
            default: rx_state_d = RX_HDR0;
        endcase
        rx_ready_d = (rx_state_d != RX_CPL);
    end

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) regs_d[i] = regs_q[i];
        if (wr_en) begin
            for (int b = 0; b < 4; b++)
                if (fbe_q[b]) regs_d[wr_idx][8*b +: 8] = wr_data[8*b +: 8];
        end
`ifdef PCIE_REGS_WRCOUNT_EN
        regs_d[0] = regs_q[0] + {31'h0, wr_en};
`endif
        rdata_d = rd_start ? regs_q[rd_idx] : rdata_q;
    end

    // TX completion sequencer; beats only advance on tx_ready so they hold under backpressure
    always_comb begin
        tx_state_d = tx_state_q;
        tx_data_d  = tx_data_q;
        tx_sop_d   = tx_sop_q;
        tx_eop_d   = tx_eop_q;
        tx_valid_d = tx_valid_q;
        case (tx_state_q)
            TX_IDLE: if (rd_start) begin
                tx_state_d = TX_B0;
                tx_valid_d = 1'b1;
                tx_sop_d   = 1'b1;
                tx_eop_d   = 1'b0;
                tx_data_d  = {cfg_busdev, 3'b000, 3'b000, 1'b0, 12'd4, 32'h4A00_0001};
            end
            TX_B0: if (tx_ready) begin
                tx_state_d = TX_B1;
                tx_sop_d   = 1'b0;
                tx_eop_d   = addr_q[2];
                tx_data_d  = {(addr_q[2] ? rdata_q : 32'h0), req_id_q, tag_q, 1'b0, addr_q[6:0]};
            end
            TX_B1: if (tx_ready) begin
                if (tx_eop_q) begin
                    tx_state_d = TX_IDLE;
                    tx_valid_d = 1'b0;
                    tx_eop_d   = 1'b0;
                    tx_data_d  = '0;
                end else begin
                    tx_state_d = TX_B2;
                    tx_eop_d   = 1'b1;
                    tx_data_d  = {32'h0, rdata_q};
                end
            end
            TX_B2: if (tx_ready) begin
                tx_state_d = TX_IDLE;
                tx_valid_d = 1'b0;
                tx_eop_d   = 1'b0;
                tx_data_d  = '0;
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rstn) begin
            rx_state_q <= RX_HDR0;
            rx_ready_q <= 1'b0;
            tx_state_q <= TX_IDLE;
            tx_data_q  <= '0;
            tx_sop_q   <= 1'b0;
            tx_eop_q   <= 1'b0;
            tx_valid_q <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VAL;
`ifdef PCIE_REGS_WRCOUNT_EN
            regs_q[0] <= '0;
`endif
        end else begin
            rx_state_q <= rx_state_d;
            rx_ready_q <= rx_ready_d;
            tx_state_q <= tx_state_d;
            tx_data_q  <= tx_data_d;
            tx_sop_q   <= tx_sop_d;
            tx_eop_q   <= tx_eop_d;
            tx_valid_q <= tx_valid_d;
            regs_q     <= regs_d;
        end
    end

    always_ff @(posedge clk_in) begin
        ft_q     <= ft_d;
        len_q    <= len_d;
        req_id_q <= req_id_d;
        tag_q    <= tag_d;
        fbe_q    <= fbe_d;
        addr_q   <= addr_d;
        rdata_q  <= rdata_d;
    end
endmodule

// File: tb/tb_pcie_reg_tlp_engine.sv
// Directed bench for pcie_reg_tlp_engine: writes/reads through RX TLPs and checks every CplD beat.
module tb_pcie_reg_tlp_engine;
    logic        clk_in = 1'b0;
    logic        rstn = 1'b0;
    logic [12:0] cfg_busdev = 13'h0A5;
    logic [63:0] rx_data = '0;
    logic        rx_sop = 1'b0;
    logic        rx_eop = 1'b0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [63:0] tx_data;
    logic        tx_sop;
    logic        tx_eop;
    logic        tx_valid;
    logic        tx_ready = 1'b1;

    int vec_cnt = 0;
    int err_cnt = 0;
    logic [7:0] tlp_tag = 8'h10;
    logic [63:0] q_data[$];
    logic        q_sop[$];
    logic        q_eop[$];

    pcie_reg_tlp_engine dut (
        .clk_in(clk_in), .rstn(rstn), .cfg_busdev(cfg_busdev),
        .rx_data(rx_data), .rx_sop(rx_sop), .rx_eop(rx_eop),
        .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_sop(tx_sop), .tx_eop(tx_eop),
        .tx_valid(tx_valid), .tx_ready(tx_ready)
    );

    always #5 clk_in = ~clk_in;

    // tx_ready only changes just after posedge, so at negedge valid&&ready means the beat transfers next edge
    always @(negedge clk_in) begin
        if (tx_valid && tx_ready) begin
            q_data.push_back(tx_data);
            q_sop.push_back(tx_sop);
            q_eop.push_back(tx_eop);
        end
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send_beat(input logic [63:0] d, input logic sop, input logic eop);
        int n = 0;
        @(negedge clk_in);
        rx_data = d; rx_sop = sop; rx_eop = eop; rx_valid = 1'b1;
        while (!rx_ready && n < 100) begin
            @(negedge clk_in);
            n++;
        end
        if (n >= 100) check_val("rx_ready_timeout", 64'd0, 64'd1);
        else @(posedge clk_in);
        #1 rx_valid = 1'b0; rx_sop = 1'b0; rx_eop = 1'b0;
    endtask

    task automatic mwr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
        send_beat({16'h0100, tlp_tag, 4'h0, be, 32'h4000_0001}, 1'b1, 1'b0);
        if (addr[2]) send_beat({data, addr}, 1'b0, 1'b1);
        else begin
            send_beat({32'h0, addr}, 1'b0, 1'b0);
            send_beat({32'h0, data}, 1'b0, 1'b1);
        end
        tlp_tag++;
    endtask

    task automatic send_mrd(input logic [31:0] addr, input logic [9:0] len, input logic [7:0] tag);
        send_beat({16'h0100, tag, 4'h0, 4'hF, 22'h0, len}, 1'b1, 1'b0);
        send_beat({32'h0, addr}, 1'b0, 1'b1);
    endtask

    task automatic collect_cpl(input string name, input logic [31:0] addr, input logic [7:0] tag,
                               input logic [31:0] exp);
        int n = 0;
        int nb;
        nb = addr[2] ? 2 : 3;
        while (q_data.size() < nb && n < 200) begin
            @(negedge clk_in);
            n++;
        end
        if (q_data.size() < nb) begin
            check_val({name, "_timeout"}, 64'(q_data.size()), 64'(nb));
        end else begin
            check_val({name, "_b0"}, q_data[0], 64'h0528_0004_4A00_0001);
            check_val({name, "_b0flags"}, {62'h0, q_sop[0], q_eop[0]}, 64'd2);
            check_val({name, "_b1"}, q_data[1],
                      {(addr[2] ? exp : 32'h0), 16'h0100, tag, 1'b0, addr[6:0]});
            check_val({name, "_b1flags"}, {62'h0, q_sop[1], q_eop[1]}, {63'h0, addr[2]});
            if (nb == 3) begin
                check_val({name, "_b2"}, q_data[2], {32'h0, exp});
                check_val({name, "_b2flags"}, {62'h0, q_sop[2], q_eop[2]}, 64'd1);
            end
        end
        repeat (3) @(negedge clk_in);
        check_val({name, "_extra_beats"}, 64'(q_data.size()), 64'(nb));
        q_data.delete(); q_sop.delete(); q_eop.delete();
    endtask

    task automatic do_read(input string name, input logic [31:0] addr, input logic [31:0] exp);
        logic [7:0] t;
        t = tlp_tag;
        tlp_tag++;
        send_mrd(addr, 10'd1, t);
        collect_cpl(name, addr, t, exp);
    endtask

    task automatic wait_tx_valid();
        int n = 0;
        @(negedge clk_in);
        while (!tx_valid && n < 100) begin
            @(negedge clk_in);
            n++;
        end
        if (n >= 100) check_val("tx_valid_timeout", 64'd0, 64'd1);
    endtask

    task automatic accept_one_beat();
        @(posedge clk_in); #1 tx_ready = 1'b1;
        @(posedge clk_in); #1 tx_ready = 1'b0;
    endtask

    logic [31:0] t2_addr [6] = '{32'h14, 32'h1C, 32'h24, 32'h2C, 32'h34, 32'h3C};
    logic [31:0] t2_data [6] = '{32'h34D9E13F, 32'h863FFC01, 32'h4954F539,
                                 32'h28B3C29E, 32'h1B6B3B92, 32'h92033EB1};

    initial begin
        logic [7:0] t;
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        check_val("rst_outputs", {60'h0, rx_ready, tx_valid, tx_sop, tx_eop}, 64'h0);
        check_val("rst_tx_data", tx_data, 64'h0);
        @(posedge clk_in); #1 rstn = 1'b1;

        mwr(32'h14, 32'h34D9E13F, 4'hF);
        do_read("t1_rd14", 32'h14, 32'h34D9E13F);

        for (int i = 0; i < 6; i++) mwr(t2_addr[i], t2_data[i], 4'hF);
        for (int i = 0; i < 6; i++) do_read($sformatf("t2_rd%0d", i), t2_addr[i], t2_data[i]);
        do_read("t2_alias114", 32'h114, 32'h34D9E13F);

        mwr(32'h20, 32'hDEADBEEF, 4'hF);
        do_read("t3_rd20", 32'h20, 32'hDEADBEEF);

        mwr(32'h2C, 32'h11223344, 4'hF);
        mwr(32'h2C, 32'hAAAABBBB, 4'h3);
        do_read("t4_be3", 32'h2C, 32'h1122BBBB);
        mwr(32'h34, 32'h00000000, 4'h0);
        do_read("t4_be0", 32'h34, 32'h1B6B3B92);

        send_beat({16'h0100, 8'h55, 8'h0F, 32'h6000_0001}, 1'b1, 1'b0);
        send_beat({32'h0000_001C, 32'h0}, 1'b0, 1'b0);
        send_beat({32'h0, 32'hFFFF_FFFF}, 1'b0, 1'b1);
        send_mrd(32'h1C, 10'd2, 8'h56);
        repeat (10) @(negedge clk_in);
        check_val("t5_no_cpl_dropped", 64'(q_data.size()), 64'd0);

        tx_ready = 1'b0;
        t = tlp_tag;
        tlp_tag++;
        send_mrd(32'h1C, 10'd1, t);
        wait_tx_valid();
        accept_one_beat();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_in);
            check_val("t5_hold_data", tx_data, {32'h863FFC01, 16'h0100, t, 8'h1C});
            check_val("t5_hold_ctl", {60'h0, tx_valid, tx_sop, tx_eop, rx_ready}, 64'hA);
        end
        @(posedge clk_in); #1 tx_ready = 1'b1;
        collect_cpl("t5_rd1c", 32'h1C, t, 32'h863FFC01);

        tx_ready = 1'b0;
        t = tlp_tag;
        tlp_tag++;
        send_mrd(32'h20, 10'd1, t);
        wait_tx_valid();
        accept_one_beat();
        #1 rstn = 1'b0;
        @(posedge clk_in); @(posedge clk_in);
        @(negedge clk_in);
        check_val("t6_rst_ctl", {60'h0, rx_ready, tx_valid, tx_sop, tx_eop}, 64'h0);
        check_val("t6_rst_data", tx_data, 64'h0);
        @(posedge clk_in); #1 rstn = 1'b1; tx_ready = 1'b1;
        q_data.delete(); q_sop.delete(); q_eop.delete();
        repeat (6) @(negedge clk_in);
        check_val("t6_no_stale", 64'(q_data.size()), 64'd0);
        do_read("t6_rd20", 32'h20, 32'h0);
        do_read("t6_rd14", 32'h14, 32'h0);

`ifdef PCIE_REGS_WRCOUNT_EN
        mwr(32'h04, 32'h12345678, 4'hF);
        mwr(32'h14, 32'h0000_0001, 4'hF);
        mwr(32'h20, 32'h0000_0002, 4'h0);
        do_read("wc_rd0", 32'h00, 32'h00000003);
`else
        mwr(32'h04, 32'h5A5A0000, 4'hF);
        do_read("idx0_rd", 32'h00, 32'h5A5A0000);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
